// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first UART receiver with a valid/ready pop buffer.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module uart_rx #(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_overrun,
  output logic       o_frame_err,
  input  logic       i_err_clr
);
  localparam int CPB = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW = $clog2(CPB);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end
  typedef enum logic [2:0] {WAIT_HIGH, IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n;
  logic s1, s2, push, ferr, pop, full, ovr;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= i_uart_rx;
      s2 <= s1;
    end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= WAIT_HIGH;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    idx_n = idx;
    sh_n = sh;
    push = 1'b0;
    ferr = 1'b0;
    case (state)
      WAIT_HIGH: begin
        cnt_n = '0;
        if (s2) state_n = IDLE;
      end
      IDLE: begin
        cnt_n = '0;
        if (!s2) state_n = START;
      end
      START: if (cnt == HALF) begin
        cnt_n = '0;
        idx_n = '0;
        state_n = s2 ? IDLE : DATA;
      end
      DATA: if (cnt == LAST) begin
        cnt_n = '0;
        sh_n[idx] = s2;
        idx_n = idx + 3'd1;
        if (idx == 3'd7) state_n = STOP;
      end
      STOP: if (cnt == LAST) begin
        cnt_n = '0;
        push = s2;
        ferr = !s2;
        state_n = s2 ? IDLE : WAIT_HIGH;
      end
      default: state_n = WAIT_HIGH;
    endcase
  end
  assign pop = o_valid & i_ready;
  // a pop in the same cycle frees the slot, so a full buffer still accepts the push
  assign ovr = push & full & ~pop;
`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [AW:0] wp, rp;
  logic [7:0] mem [FIFO_DEPTH];
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign o_valid = wp != rp;
  assign o_data = mem[rp[AW-1:0]];
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push & ~ovr) begin
        mem[wp[AW-1:0]] <= sh;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
    end
`else
  logic [7:0] hold;
  logic hv;
  assign full = hv;
  assign o_valid = hv;
  assign o_data = hold;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      hold <= '0;
      hv <= 1'b0;
    end else if (push & ~ovr) begin
      hold <= sh;
      hv <= 1'b1;
    end else if (pop) begin
      hv <= 1'b0;
    end
`endif
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      o_overrun <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_overrun <= ovr | (o_overrun & ~i_err_clr);
      o_frame_err <= ferr | (o_frame_err & ~i_err_clr);
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed checks of uart_rx at CPB=104; buffer depth follows UART_RX_FIFO_EN.
module tb_uart_rx;
  localparam int CPB = 104;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, ready = 1'b0, err_clr = 1'b0;
  logic [7:0] data;
  logic valid, ovr, ferr;
  int passed = 0, total = 0;
  logic [7:0] t2 [5] = '{8'hA3, 8'h01, 8'hFF, 8'h00, 8'h7E};
  logic [7:0] fill [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  uart_rx dut (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx), .o_data(data), .o_valid(valid),
    .i_ready(ready), .o_overrun(ovr), .o_frame_err(ferr), .i_err_clr(err_clr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b, input logic stop = 1'b1, input int slen = 1);
    rx = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(CPB);
    end
    rx = stop;
    cyc(CPB * slen);
    rx = 1'b1;
    cyc(4);
  endtask
  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, valid, 1'b1);
    chk(tag, data, exp);
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
  endtask
  initial begin
    cyc(3);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_ferr", ferr, 0);
    rst = 1'b0;
    cyc(5);
    // 1: first byte, exact o_valid timing (stop sample 991 cycles after the line falls)
    fork
      send(8'h55);
      begin
        cyc(990);
        chk("t1_pre", valid, 0);
        cyc(1);
        chk("t1_rise", valid, 1);
        chk("t1_data", data, 8'h55);
      end
    join
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
    chk("t1_pop", valid, 0);
    chk("t1_ovr", ovr, 0);
    chk("t1_ferr", ferr, 0);
    // 2: overrun
    for (int i = 0; i < 4; i++) send(t2[i]);
    chk("t2_ovr4", ovr, DEPTH < 4);
    send(t2[4]);
    chk("t2_ovr5", ovr, 1);
    for (int i = 0; i < DEPTH; i++) pop_chk($sformatf("t2_pop%0d", i), t2[i]);
    chk("t2_empty", valid, 0);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    chk("t2_clr", ovr, 0);
    // 3: short low pulse rejected as a glitch
    rx = 1'b0;
    cyc(20);
    rx = 1'b1;
    cyc(200);
    chk("t3_valid", valid, 0);
    chk("t3_ferr", ferr, 0);
    send(8'hC3);
    pop_chk("t3_c3", 8'hC3);
    chk("t3_empty", valid, 0);
    // 4: break with stop low for three bit times
    fork
      send(8'h00, 1'b0, 3);
      begin
        cyc(CPB * 12 - 5);
        chk("t4_ferr", ferr, 1);
        chk("t4_nopush", valid, 0);
      end
    join
    cyc(50);
    chk("t4_after", valid, 0);
    send(8'h5A);
    pop_chk("t4_5a", 8'h5A);
    chk("t4_sticky", ferr, 1);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    chk("t4_clr", ferr, 0);
    fork
      send(8'h00, 1'b0, 1);
      begin
        cyc(990);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
      end
    join
    chk("t4_setwins", ferr, 1);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    chk("t4_clr2", ferr, 0);
    // 5: push and pop together while full
    for (int i = 0; i < DEPTH; i++) send(fill[i]);
    fork
      send(8'h99);
      begin
        cyc(990);
        ready = 1'b1;
        cyc(1);
        ready = 1'b0;
      end
    join
    chk("t5_ovr", ovr, 0);
    for (int i = 1; i < DEPTH; i++) pop_chk($sformatf("t5_pop%0d", i), fill[i]);
    pop_chk("t5_last", 8'h99);
    chk("t5_empty", valid, 0);
    // 6: async reset mid-frame
    send(8'h00, 1'b0, 1);
    send(8'h61);
    send(8'h62);
    chk("t6_pre_valid", valid, 1);
    chk("t6_pre_ferr", ferr, 1);
    fork
      send(8'hE7);
      begin
        cyc(CPB * 5 + 50);
        #2 rst = 1'b1;
        #1;
        chk("t6_valid", valid, 0);
        chk("t6_ferr", ferr, 0);
        chk("t6_ovr", ovr, 0);
        chk("t6_data", data, 0);
      end
    join
    cyc(2);
    rst = 1'b0;
    cyc(5);
    chk("t6_after", valid, 0);
    send(8'h3C);
    pop_chk("t6_3c", 8'h3C);
    chk("t6_empty", valid, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
